// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes, default latencies, FSM states.
package e_mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mdu_state_e;

endpackage

// File: rtl/e_mdu_if.sv
// Pipeline-to-MDU signal bundle; the pipeline side is master, the MDU is slave.
interface e_mdu_if;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output mdu_op, rs_val, rt_val,
    input  busy, hilo_out, hi, lo
  );

  modport slave (
    input  mdu_op, rs_val, rt_val,
    output busy, hilo_out, hi, lo
  );
endinterface

// File: rtl/e_mdu_calc.sv
// Combinational product / quotient / remainder for the MDU, result packed as {hi, lo}.
// MDU_MADD_EN adds the accumulate forms using the acc input.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [63:0] acc,
`endif
  output logic [63:0] res,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic        ovf;

  always_comb begin
    prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u   = {32'b0, a} * {32'b0, b};
    div_zero = (b == 32'b0);
    ovf      = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    // Guard the divider so a zero divisor or the one signed overflow never reaches it.
    if (!div_zero) begin
      q_u = a / b;
      r_u = a % b;
      if (ovf) begin
        q_s = a;
        r_s = '0;
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
      end
    end
  end

  always_comb begin
    res = '0;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {r_s, q_s};
      OP_DIVU:  res = {r_u, q_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_MSUBU: res = acc - prod_u;
`endif
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div, serves mfhi/mflo/mthi/mtlo.
// MDU_MADD_EN enables madd/maddu/msub/msubu on the multiply latency.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave bus
);

  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

  mdu_state_e  state, state_nxt;
  logic [7:0]  cnt;
  logic [63:0] res_tmp;
  logic        skip_tmp;
  logic [31:0] hi_q, lo_q;
  logic        is_mul, is_div, start, commit, busy;
  logic [63:0] calc_res;
  logic        calc_div_zero;

  e_mdu_calc u_calc (
    .op       (bus.mdu_op),
    .a        (bus.rs_val),
    .b        (bus.rt_val),
`ifdef MDU_MADD_EN
    .acc      ({hi_q, lo_q}),
`endif
    .res      (calc_res),
    .div_zero (calc_div_zero)
  );

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (bus.mdu_op)
      OP_MULT, OP_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
      OP_DIV, OP_DIVU:   is_div = 1'b1;
      default: ;
    endcase
  end

  assign busy  = (cnt != 8'd0) || (state == S_RUN);
  assign start = (is_mul || is_div) && !busy;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (cnt == 8'd0) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result is captured at the start edge and held until the latency expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      res_tmp  <= '0;
      skip_tmp <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (start) begin
        cnt      <= is_div ? DIV_LOAD : MULT_LOAD;
        res_tmp  <= calc_res;
        skip_tmp <= is_div && calc_div_zero;
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (commit) begin
        if (!skip_tmp) begin
          hi_q <= res_tmp[63:32];
          lo_q <= res_tmp[31:0];
        end
      end else if (!busy) begin
        if (bus.mdu_op == OP_MTHI) hi_q <= bus.rs_val;
        if (bus.mdu_op == OP_MTLO) lo_q <= bus.rs_val;
      end
    end
  end

  always_comb begin
    bus.hilo_out = '0;
    if (bus.mdu_op == OP_MFHI) bus.hilo_out = hi_q;
    if (bus.mdu_op == OP_MFLO) bus.hilo_out = lo_q;
  end

  assign bus.busy = busy;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO/busy expectations for each op class.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  e_mdu_if bus ();

  e_mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge with busy low after the op.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string tag);
    int cnt;
    bus.mdu_op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.mdu_op = OP_NOP;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, 32'(cnt), 32'(n));
  endtask

  // Same, but a second op is presented two cycles in, while busy.
  task automatic run_op_int(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op2, input logic [31:0] a2, input logic [31:0] b2,
                            input int n, input string tag);
    int cnt;
    bus.mdu_op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.mdu_op = OP_NOP;
    @(negedge clk);
    bus.mdu_op = op2;
    bus.rs_val = a2;
    bus.rt_val = b2;
    @(negedge clk);
    bus.mdu_op = OP_NOP;
    cnt = 2;
    while (bus.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, 32'(cnt), 32'(n));
  endtask

  task automatic chk_hilo(input logic [31:0] eh, input logic [31:0] el, input string tag);
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
  endtask

  task automatic read_hilo(input logic [3:0] op, input logic [31:0] exp, input string tag);
    bus.mdu_op = op;
    #1;
    chk(tag, bus.hilo_out, exp);
    bus.mdu_op = OP_NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.mdu_op = OP_NOP;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk_hilo(32'h0, 32'h0, "rst");
    read_hilo(OP_MFHI, 32'h0, "rst_mfhi");
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 5, "mult");
    chk_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    read_hilo(OP_MFHI, 32'hFFFF_FFFF, "mult_mfhi");
    read_hilo(OP_MFLO, 32'hFFFF_FFFE, "mult_mflo");
    read_hilo(OP_NOP, 32'h0, "nop_hilo");

    run_op_int(OP_MULTU, 32'hFFFF_FFFF, 32'd2, OP_MULT, 32'hFFFF_FFFF, 32'd2, 5, "multu");
    chk_hilo(32'h0000_0001, 32'hFFFF_FFFE, "multu");

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, "div_m7_2");
    chk_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(OP_DIVU, 32'd7, 32'd2, 10, "divu_7_2");
    chk_hilo(32'd1, 32'd3, "divu_7_2");
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 10, "div_7_m2");
    chk_hilo(32'd1, 32'hFFFF_FFFD, "div_7_m2");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
    chk_hilo(32'h0, 32'h8000_0000, "div_ovf");

    run_op_int(OP_DIVU, 32'd9, 32'd4, OP_MTHI, 32'hDEAD_0000, 32'd0, 10, "divu_mthi");
    chk_hilo(32'd1, 32'd2, "divu_mthi");

    run_op(OP_MTHI, 32'h1234_5678, 32'd0, 0, "mthi");
    run_op(OP_MTLO, 32'hCAFE_F00D, 32'd0, 0, "mtlo");
    chk_hilo(32'h1234_5678, 32'hCAFE_F00D, "mt");
    run_op(OP_DIV, 32'd5, 32'd0, 10, "div0");
    chk_hilo(32'h1234_5678, 32'hCAFE_F00D, "div0");

    bus.mdu_op = OP_DIV;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    @(negedge clk);
    bus.mdu_op = OP_NOP;
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk_hilo(32'h0, 32'h0, "abort");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_late_busy", 32'(bus.busy), 32'd0);
    chk_hilo(32'h0, 32'h0, "abort_late");

    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 0, "mtlo_acc");
`ifdef MDU_MADD_EN
    run_op(OP_MADDU, 32'd1, 32'd1, 5, "maddu");
    chk_hilo(32'd1, 32'd0, "maddu");
    run_op(OP_MSUB, 32'd2, 32'd3, 5, "msub");
    chk_hilo(32'd0, 32'hFFFF_FFFA, "msub");
    run_op(OP_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "madd");
    chk_hilo(32'd0, 32'hFFFF_FFFB, "madd");
`else
    run_op(OP_MADDU, 32'd1, 32'd1, 0, "maddu_off");
    chk_hilo(32'd0, 32'hFFFF_FFFF, "maddu_off");
    run_op(OP_MSUB, 32'd2, 32'd3, 0, "msub_off");
    chk_hilo(32'd0, 32'hFFFF_FFFF, "msub_off");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
